// File: rtl/lock_sequencer.sv
// Lock acquisition controller for one servo channel.
// Walks IDLE -> SETTLE -> ACQUIRE -> LOCKED. Loss of lock triggers a relock
// attempt back in ACQUIRE. Acquire timeout or running out of relock attempts
// parks the channel in FAULT until the host clears it.
module lock_sequencer #(
  parameter int TMO_WIDTH   = 32,
  parameter int RETRY_WIDTH = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   enable_in,
  input  logic signed [15:0]     minval_in,
  input  logic signed [15:0]     maxval_in,
  input  logic signed [15:0]     signal_in,
  input  logic [1:0]             railed_in,
  input  logic [15:0]            settle_cycles_in,
  input  logic [15:0]            lock_cycles_in,
  input  logic [15:0]            unlock_cycles_in,
  input  logic [TMO_WIDTH-1:0]   timeout_in,
  input  logic [RETRY_WIDTH-1:0] max_retries_in,
  input  logic                   fault_clear_in,
  output logic                   loop_enable_out,
  output logic                   relock_on_out,
  output logic                   clear_out,
  output logic                   locked_out,
  output logic                   fault_out,
  output logic [2:0]             state_out,
  output logic [RETRY_WIDTH-1:0] retry_count_out
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_ACQUIRE = 3'd2;
  localparam logic [2:0] S_LOCKED  = 3'd3;
  localparam logic [2:0] S_FAULT   = 3'd4;

  localparam logic [TMO_WIDTH-1:0]   TMO_ONE   = {{(TMO_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RETRY_WIDTH-1:0] RETRY_ONE = {{(RETRY_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]             state_q, state_d;
  logic                   in_win_q, in_win_d;
  logic [15:0]            settle_cnt_q, settle_cnt_d;
  logic [15:0]            win_cnt_q, win_cnt_d;
  logic [15:0]            bad_cnt_q, bad_cnt_d;
  logic [TMO_WIDTH-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [RETRY_WIDTH-1:0] retry_q, retry_d;

  logic [15:0]            lock_tgt, unlock_tgt;
  logic [15:0]            settle_inc, win_next, bad_next;
  logic [TMO_WIDTH-1:0]   tmo_next;
  logic [RETRY_WIDTH-1:0] retry_inc;

  // A zero dwell setting means a single cycle is enough.
  assign lock_tgt   = (lock_cycles_in   == 16'd0) ? 16'd1 : lock_cycles_in;
  assign unlock_tgt = (unlock_cycles_in == 16'd0) ? 16'd1 : unlock_cycles_in;

  // Saturating counter candidates; run counters restart on a break in the run.
  assign settle_inc = (settle_cnt_q == 16'hFFFF) ? settle_cnt_q : settle_cnt_q + 16'd1;
  assign win_next   = !in_win_q ? 16'd0 :
                      ((win_cnt_q == 16'hFFFF) ? win_cnt_q : win_cnt_q + 16'd1);
  assign bad_next   = in_win_q ? 16'd0 :
                      ((bad_cnt_q == 16'hFFFF) ? bad_cnt_q : bad_cnt_q + 16'd1);
  assign tmo_next   = (tmo_cnt_q == {TMO_WIDTH{1'b1}}) ? tmo_cnt_q : tmo_cnt_q + TMO_ONE;
  assign retry_inc  = (retry_q == {RETRY_WIDTH{1'b1}}) ? retry_q : retry_q + RETRY_ONE;

  // Window qualification: strictly inside the bounds and loop filter not railed.
  assign in_win_d = (signal_in > minval_in) && (signal_in < maxval_in) &&
                    (railed_in == 2'b00);

  // Next-state and counter update; limits compare with >= so a limit lowered
  // below the running count takes effect immediately.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    win_cnt_d    = win_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    retry_d      = retry_q;

    case (state_q)
      S_IDLE: state_d = S_SETTLE;
      S_SETTLE: begin
        if (settle_cnt_q >= settle_cycles_in) state_d = S_ACQUIRE;
        else                                  settle_cnt_d = settle_inc;
      end
      S_ACQUIRE: begin
        win_cnt_d = win_next;
        tmo_cnt_d = tmo_next;
        if (win_next >= lock_tgt)
          state_d = S_LOCKED;
        else if ((timeout_in != '0) && (tmo_next >= timeout_in))
          state_d = S_FAULT;
      end
      S_LOCKED: begin
        bad_cnt_d = bad_next;
        if (bad_next >= unlock_tgt) begin
          if (retry_q >= max_retries_in) begin
            state_d = S_FAULT;
          end else begin
            retry_d = retry_inc;
            state_d = S_ACQUIRE;
          end
        end
      end
      S_FAULT: if (fault_clear_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (!enable_in) state_d = S_IDLE;

    // Every state entry starts its dwell/run counters from zero.
    if (state_d != state_q) begin
      settle_cnt_d = 16'd0;
      win_cnt_d    = 16'd0;
      bad_cnt_d    = 16'd0;
      tmo_cnt_d    = '0;
    end
    if (state_d == S_IDLE) retry_d = '0;
  end

  // State, counters and Moore outputs decoded from the next state so they line
  // up with state_out; clear fires only on the way into SETTLE.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q         <= S_IDLE;
      in_win_q        <= 1'b0;
      settle_cnt_q    <= 16'd0;
      win_cnt_q       <= 16'd0;
      bad_cnt_q       <= 16'd0;
      tmo_cnt_q       <= '0;
      retry_q         <= '0;
      loop_enable_out <= 1'b0;
      relock_on_out   <= 1'b0;
      clear_out       <= 1'b0;
      locked_out      <= 1'b0;
      fault_out       <= 1'b0;
    end else begin
      state_q         <= state_d;
      in_win_q        <= in_win_d;
      settle_cnt_q    <= settle_cnt_d;
      win_cnt_q       <= win_cnt_d;
      bad_cnt_q       <= bad_cnt_d;
      tmo_cnt_q       <= tmo_cnt_d;
      retry_q         <= retry_d;
      loop_enable_out <= (state_d == S_ACQUIRE) || (state_d == S_LOCKED);
      relock_on_out   <= (state_d == S_ACQUIRE) || (state_d == S_LOCKED);
      clear_out       <= (state_d == S_SETTLE) && (state_q != S_SETTLE);
      locked_out      <= (state_d == S_LOCKED);
      fault_out       <= (state_d == S_FAULT);
    end
  end

  assign state_out       = state_q;
  assign retry_count_out = retry_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all outputs compared every cycle to a
// behavioural model based on state age and in-window run lengths.
module tb_lock_sequencer;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               enable = 1'b0;
  logic signed [15:0] minv = -16'sd100;
  logic signed [15:0] maxv = 16'sd100;
  logic signed [15:0] sig = 16'sd0;
  logic [1:0]         railed = 2'b00;
  logic [15:0]        settle = 16'd3;
  logic [15:0]        lockc = 16'd5;
  logic [15:0]        unlockc = 16'd2;
  logic [31:0]        tmo = 32'd0;
  logic [7:0]         maxr = 8'd3;
  logic               fc = 1'b0;

  logic               loop_en, relock_on, clr, locked, fault;
  logic [2:0]         state_o;
  logic [7:0]         retry_o;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  lock_sequencer #(.TMO_WIDTH(32), .RETRY_WIDTH(8)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .enable_in(enable),
    .minval_in(minv), .maxval_in(maxv), .signal_in(sig), .railed_in(railed),
    .settle_cycles_in(settle), .lock_cycles_in(lockc), .unlock_cycles_in(unlockc),
    .timeout_in(tmo), .max_retries_in(maxr), .fault_clear_in(fc),
    .loop_enable_out(loop_en), .relock_on_out(relock_on), .clear_out(clr),
    .locked_out(locked), .fault_out(fault), .state_out(state_o),
    .retry_count_out(retry_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: state number, cycles spent in the state, length of the
  // current good/bad run of the (one-cycle-delayed) window flag, relock count.
  int m_st = 0, m_age = 0, m_run = 0, m_bad = 0, m_retry = 0;
  bit m_win = 0;

  always @(posedge clk or negedge rst_n) begin : model
    int nx, lk, ul;
    if (!rst_n) begin
      m_st = 0; m_age = 0; m_run = 0; m_bad = 0; m_retry = 0; m_win = 0;
    end else begin
      nx = m_st;
      lk = (lockc == 0) ? 1 : int'(lockc);
      ul = (unlockc == 0) ? 1 : int'(unlockc);
      case (m_st)
        0: nx = 1;
        1: if (m_age >= int'(settle)) nx = 2;
        2: begin
          m_run = m_win ? m_run + 1 : 0;
          if (m_run >= lk) nx = 3;
          else if (tmo != 0 && longint'(m_age) + 1 >= longint'(tmo)) nx = 4;
        end
        3: begin
          m_bad = !m_win ? m_bad + 1 : 0;
          if (m_bad >= ul) begin
            if (m_retry >= int'(maxr)) nx = 4;
            else begin m_retry = m_retry + 1; nx = 2; end
          end
        end
        4: if (fc) nx = 0;
        default: nx = 0;
      endcase
      if (!enable) nx = 0;
      if (nx != m_st) begin m_age = 0; m_run = 0; m_bad = 0; end
      else m_age = m_age + 1;
      if (nx == 0) m_retry = 0;
      m_st = nx;
      m_win = (sig > minv) && (sig < maxv) && (railed == 2'b00);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      logic [2:0] e_st;
      logic       e_run, e_clr, e_lk, e_ft;
      e_st  = 3'(m_st);
      e_run = (m_st == 2) || (m_st == 3);
      e_clr = (m_st == 1) && (m_age == 0);
      e_lk  = (m_st == 3);
      e_ft  = (m_st == 4);
      checks++;
      if (state_o !== e_st || loop_en !== e_run || relock_on !== e_run ||
          clr !== e_clr || locked !== e_lk || fault !== e_ft ||
          retry_o !== 8'(m_retry)) begin
        errors++;
        $display("FAIL model_cmp t=%0t got st=%0d le=%b ro=%b clr=%b lk=%b ft=%b rc=%0d want st=%0d le=%b ro=%b clr=%b lk=%b ft=%b rc=%0d",
                 $time, state_o, loop_en, relock_on, clr, locked, fault, retry_o,
                 e_st, e_run, e_run, e_clr, e_lk, e_ft, m_retry);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int maxc);
    int n;
    n = 0;
    while (state_o !== s && n < maxc) begin
      tick();
      n++;
    end
    chk("wait_state", 32'(state_o), 32'(s));
  endtask

  initial begin
    logic [2:0] exp_seq [10];
    exp_seq = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};

    // Power-on reset.
    #1 rst_n = 1'b0;
    #1;
    chk("reset_state", 32'(state_o), 0);
    chk("reset_outs", {loop_en, relock_on, clr, locked, fault}, 0);
    started = 1;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Enable: one SETTLE clear, four SETTLE cycles, five in-window ACQUIRE cycles.
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("seq_state", 32'(state_o), 32'(exp_seq[i]));
      chk("seq_clear", 32'(clr), (i == 0) ? 1 : 0);
    end
    chk("seq_locked", 32'(locked), 1);

    // One bad cycle does not unlock with unlock=2.
    sig = 16'sd200; tick();
    sig = 16'sd0;   tick();
    chk("glitch_hold", 32'(state_o), 3);
    tick();
    chk("glitch_hold2", 32'(state_o), 3);
    // Two bad cycles relock.
    sig = 16'sd200; tick(); tick();
    chk("bad1_hold", 32'(state_o), 3);
    tick();
    chk("relock_state", 32'(state_o), 2);
    chk("relock_retry", 32'(retry_o), 1);
    chk("relock_on", 32'(relock_on), 1);

    // Retries exhausted -> FAULT, then clear back through IDLE.
    sig = 16'sd0;
    wait_state(3'd3, 20);
    maxr = 8'd1;
    sig = 16'sd200; tick(); tick(); tick();
    chk("fault_state", 32'(state_o), 4);
    chk("fault_loop", 32'(loop_en), 0);
    chk("fault_out", 32'(fault), 1);
    fc = 1'b1; tick(); fc = 1'b0;
    chk("fclr_idle", 32'(state_o), 0);
    tick();
    chk("fclr_settle", 32'(state_o), 1);
    chk("fclr_clear", 32'(clr), 1);
    chk("fclr_retry", 32'(retry_o), 0);

    // Acquire timeout of 100 cycles with the signal never in window.
    tmo = 32'd100;
    wait_state(3'd2, 20);
    repeat (99) tick();
    chk("tmo_before", 32'(state_o), 2);
    tick();
    chk("tmo_fault", 32'(state_o), 4);
    tmo = 32'd0;
    fc = 1'b1; tick(); fc = 1'b0;
    wait_state(3'd2, 20);
    repeat (10000) tick();
    chk("tmo_never", 32'(state_o), 2);

    // Railed high while in window forces a relock with unlock=1.
    sig = 16'sd0;
    wait_state(3'd3, 20);
    unlockc = 16'd0;
    railed = 2'b10;
    tick();
    chk("rail_hold", 32'(state_o), 3);
    tick();
    chk("rail_relock", 32'(state_o), 2);
    chk("rail_retry", 32'(retry_o), 1);

    // Reset in the middle of LOCKED clears outputs immediately.
    railed = 2'b00;
    wait_state(3'd3, 20);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state_o), 0);
    chk("mid_rst_outs", {loop_en, relock_on, clr, locked, fault}, 0);
    chk("mid_rst_retry", 32'(retry_o), 0);
    tick();
    rst_n = 1'b1;

    // Randomized traffic against the model.
    maxr = 8'd2; unlockc = 16'd1; lockc = 16'd2; settle = 16'd1; tmo = 32'd30;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 7) == 0) sig = 16'(int'($urandom_range(0, 300)) - 150);
      railed = ($urandom_range(0, 30) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      enable = ($urandom_range(0, 199) != 0);
      fc = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 99) == 0) begin
        settle  = 16'($urandom_range(0, 4));
        lockc   = 16'($urandom_range(0, 4));
        unlockc = 16'($urandom_range(0, 3));
        tmo     = 32'($urandom_range(0, 40));
        maxr    = 8'($urandom_range(0, 3));
        minv    = 16'(int'($urandom_range(0, 60)) - 120);
        maxv    = 16'($urandom_range(60, 120));
      end
      tick();
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
